// File: rtl/i2c_responder_pkg.sv
// Shared types and constants for the I2C register responder.
// The state enum mirrors the byte/ACK phases of the bus transaction.
package i2c_responder_pkg;

    localparam int BYTE_WIDTH = 8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        DEVICE_ADDRESS,
        ADDRESS_ACK,
        REGISTER_ADDRESS,
        REGISTER_ACK,
        WRITE_DATA,
        WRITE_ACK,
        READ_DATA,
        READ_ACK,
        IGNORE
    } responder_state_t;

endpackage

// File: rtl/i2c_register_responder_if.sv
// Local side port of the responder: register read-back and bus write observation.
interface i2c_register_responder_if;
    import i2c_responder_pkg::*;

    logic [BYTE_WIDTH-1:0] user_address;
    logic [BYTE_WIDTH-1:0] user_read_data;
    logic                  write_strobe;
    logic [BYTE_WIDTH-1:0] write_address;
    logic [BYTE_WIDTH-1:0] write_data;
    logic                  busy;

    modport slave (
        input  user_address,
        output user_read_data,
        output write_strobe,
        output write_address,
        output write_data,
        output busy
    );

    modport master (
        output user_address,
        input  user_read_data,
        input  write_strobe,
        input  write_address,
        input  write_data,
        input  busy
    );

endinterface

// File: rtl/i2c_bus_conditioner.sv
// Synchronizes SCL/SDA and turns them into registered SCL edge and START/STOP pulses.
module i2c_bus_conditioner (
    input  logic clock,
    input  logic reset_n,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_detected,
    output logic stop_detected,
    output logic sda_bit
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;

    // Idle bus is high, so synchronizers reset to 1 to avoid phantom edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync       <= 2'b11;
            sda_sync       <= 2'b11;
            scl_prev       <= 1'b1;
            sda_prev       <= 1'b1;
            scl_rise       <= 1'b0;
            scl_fall       <= 1'b0;
            start_detected <= 1'b0;
            stop_detected  <= 1'b0;
            sda_bit        <= 1'b1;
        end else begin
            scl_sync       <= {scl_sync[0], scl_pin};
            sda_sync       <= {sda_sync[0], sda_pin};
            scl_prev       <= scl_sync[1];
            sda_prev       <= sda_sync[1];
            scl_rise       <= scl_sync[1] & ~scl_prev;
            scl_fall       <= ~scl_sync[1] & scl_prev;
            start_detected <= scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
            stop_detected  <= scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];
            sda_bit        <= sda_sync[1];
        end
    end

endmodule

// File: rtl/i2c_register_responder.sv
// I2C target answering one 7-bit address and exposing a byte-wide register file.
// SDA is open-drain (driven low or released); SCL is never stretched.
module i2c_register_responder
    import i2c_responder_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h11,
    parameter int         REGISTER_DEPTH = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic external_serial_clock,
    inout  wire  external_serial_data,
    i2c_register_responder_if.slave local_port
);

    localparam int INDEX_W = (REGISTER_DEPTH > 1) ? $clog2(REGISTER_DEPTH) : 1;

    typedef logic [BYTE_WIDTH-1:0] byte_t;

    function automatic logic in_range(input byte_t address);
        return {1'b0, address} < 9'(REGISTER_DEPTH);
    endfunction

    logic scl_rise, scl_fall, start_detected, stop_detected, sda_bit;

    i2c_bus_conditioner u_bus_conditioner (
        .clock          (clock),
        .reset_n        (reset_n),
        .scl_pin        (external_serial_clock),
        .sda_pin        (external_serial_data),
        .scl_rise       (scl_rise),
        .scl_fall       (scl_fall),
        .start_detected (start_detected),
        .stop_detected  (stop_detected),
        .sda_bit        (sda_bit)
    );

    responder_state_t state_q, state_d;
    logic [3:0] bit_count_q, bit_count_d;
    byte_t      shift_q, shift_d;
    byte_t      pointer_q, pointer_d;
    logic       sda_low_q, sda_low_d;
    logic       busy_q, busy_d;
    logic       read_mode_q, read_mode_d;
    logic       master_ack_q, master_ack_d;
    logic       strobe_q, strobe_d;
    byte_t      write_address_q, write_address_d;
    byte_t      write_data_q, write_data_d;
    logic       register_write;
    logic       byte_done;

    byte_t registers [REGISTER_DEPTH];
    byte_t pointer_data;
    byte_t next_pointer;
    byte_t next_pointer_data;

    assign next_pointer      = pointer_q + 8'd1;
    assign pointer_data      = in_range(pointer_q) ? registers[pointer_q[INDEX_W-1:0]] : 8'hFF;
    assign next_pointer_data = in_range(next_pointer) ? registers[next_pointer[INDEX_W-1:0]] : 8'hFF;
    assign byte_done         = (bit_count_q == 4'(BYTE_WIDTH));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            bit_count_q     <= '0;
            shift_q         <= '0;
            pointer_q       <= '0;
            sda_low_q       <= 1'b0;
            busy_q          <= 1'b0;
            read_mode_q     <= 1'b0;
            master_ack_q    <= NACK;
            strobe_q        <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
        end else begin
            state_q         <= state_d;
            bit_count_q     <= bit_count_d;
            shift_q         <= shift_d;
            pointer_q       <= pointer_d;
            sda_low_q       <= sda_low_d;
            busy_q          <= busy_d;
            read_mode_q     <= read_mode_d;
            master_ack_q    <= master_ack_d;
            strobe_q        <= strobe_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
        end
    end

    // The DEVICE_ADDRESS parameter shadows the imported state literal, hence the package scope.
    always_comb begin
        state_d         = state_q;
        bit_count_d     = bit_count_q;
        shift_d         = shift_q;
        pointer_d       = pointer_q;
        sda_low_d       = sda_low_q;
        busy_d          = busy_q;
        read_mode_d     = read_mode_q;
        master_ack_d    = master_ack_q;
        strobe_d        = 1'b0;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        register_write  = 1'b0;

        if (start_detected) begin
            state_d     = i2c_responder_pkg::DEVICE_ADDRESS;
            bit_count_d = '0;
            sda_low_d   = 1'b0;
            busy_d      = 1'b0;
        end else if (stop_detected) begin
            state_d     = IDLE;
            bit_count_d = '0;
            sda_low_d   = 1'b0;
            busy_d      = 1'b0;
        end else begin
            if (scl_rise && (state_q inside {i2c_responder_pkg::DEVICE_ADDRESS,
                                             REGISTER_ADDRESS, WRITE_DATA})) begin
                shift_d     = {shift_q[BYTE_WIDTH-2:0], sda_bit};
                bit_count_d = bit_count_q + 4'd1;
            end

            case (state_q)
                i2c_responder_pkg::DEVICE_ADDRESS: begin
                    if (scl_fall && byte_done) begin
                        bit_count_d = '0;
                        if (shift_q[7:1] == DEVICE_ADDRESS) begin
                            state_d     = ADDRESS_ACK;
                            sda_low_d   = 1'b1;
                            busy_d      = 1'b1;
                            read_mode_d = shift_q[0];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDRESS_ACK: begin
                    if (scl_fall) begin
                        if (read_mode_q) begin
                            state_d   = READ_DATA;
                            shift_d   = pointer_data;
                            sda_low_d = ~pointer_data[BYTE_WIDTH-1];
                        end else begin
                            state_d   = REGISTER_ADDRESS;
                            sda_low_d = 1'b0;
                        end
                    end
                end
                REGISTER_ADDRESS: begin
                    if (scl_fall && byte_done) begin
                        bit_count_d = '0;
                        pointer_d   = shift_q;
                        state_d     = REGISTER_ACK;
                        sda_low_d   = 1'b1;
                    end
                end
                REGISTER_ACK: begin
                    if (scl_fall) begin
                        state_d   = WRITE_DATA;
                        sda_low_d = 1'b0;
                    end
                end
                WRITE_DATA: begin
                    if (scl_fall && byte_done) begin
                        bit_count_d = '0;
                        state_d     = WRITE_ACK;
                        sda_low_d   = 1'b1;
                        pointer_d   = next_pointer;
                        if (in_range(pointer_q)) begin
                            register_write  = 1'b1;
                            strobe_d        = 1'b1;
                            write_address_d = pointer_q;
                            write_data_d    = shift_q;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        state_d   = WRITE_DATA;
                        sda_low_d = 1'b0;
                    end
                end
                READ_DATA: begin
                    if (scl_rise) begin
                        bit_count_d = bit_count_q + 4'd1;
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            bit_count_d  = '0;
                            state_d      = READ_ACK;
                            sda_low_d    = 1'b0;
                            master_ack_d = NACK;
                        end else begin
                            shift_d   = {shift_q[BYTE_WIDTH-2:0], 1'b0};
                            sda_low_d = ~shift_q[BYTE_WIDTH-2];
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        master_ack_d = sda_bit;
                    end else if (scl_fall) begin
                        if (master_ack_q == ACK) begin
                            state_d   = READ_DATA;
                            pointer_d = next_pointer;
                            shift_d   = next_pointer_data;
                            sda_low_d = ~next_pointer_data[BYTE_WIDTH-1];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                IDLE, IGNORE: begin
                end
                default: begin
                    state_d   = IDLE;
                    sda_low_d = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REGISTER_DEPTH; i++) begin
                registers[i] <= '0;
            end
        end else if (register_write) begin
            registers[pointer_q[INDEX_W-1:0]] <= shift_q;
        end
    end

    assign external_serial_data = sda_low_q ? 1'b0 : 1'bz;

    assign local_port.user_read_data = in_range(local_port.user_address)
                                     ? registers[local_port.user_address[INDEX_W-1:0]]
                                     : 8'hFF;
    assign local_port.write_strobe   = strobe_q;
    assign local_port.write_address  = write_address_q;
    assign local_port.write_data     = write_data_q;
    assign local_port.busy           = busy_q;

endmodule

// File: doc/i2c_register_responder.md
# i2c_register_responder

- Synthesizable I2C target (responder) for the other end of the bus driven by `i2c_master`.
- Answers a fixed 7-bit device address and exposes a small byte-wide register file over the bus, using the master's framing:
  - write: START, addr+W, register byte, data bytes, STOP
  - read: START, addr+W, register byte, repeated START, addr+R, data bytes, STOP
- Bus pins are open-drain; the block never stretches SCL.
- A local side port lets on-chip logic read registers and observe bus writes.

## Interface
- `DEVICE_ADDRESS`, 7'h11: the address this target ACKs.
- `REGISTER_DEPTH`, 16: number of implemented 8-bit registers (1..256).
- `clock`  in  1: system clock, all logic on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `external_serial_clock`  in  1: SCL, read only, never driven.
- `external_serial_data`  inout  1: SDA, driven only to 0 (driven low or high-Z).
- `user_address`  in  8: local read address.
- `user_read_data`  out  8: combinational read of `user_address`; 8'hFF if out of range.
- `write_strobe`  out  1: one-cycle pulse per bus data byte written in range.
- `write_address`  out  8: register written; valid with `write_strobe`.
- `write_data`  out  8: byte written; valid with `write_strobe`.
- `busy`  out  1: high from an address match until STOP or START.

## Operation
SCL and SDA each pass through a 2-flop synchronizer. The block edge-detects on the synchronized copies:
- START: SDA falls while SCL is high. Valid in any state, including repeated START. Go to DEVICE_ADDRESS and clear the bit counter.
- STOP: SDA rises while SCL is high. Valid in any state. Go to IDLE, release SDA, drop `busy`.
- Sample SDA on the SCL rising edge, MSB first. Change the SDA drive only on the SCL falling edge.

States and transitions:
- IDLE: wait for START.
- DEVICE_ADDRESS: shift 8 bits.
  - Match with W: go to ADDRESS_ACK.
  - Match with R: go to ADDRESS_ACK, then READ_DATA.
  - Mismatch: go to IGNORE. Do not ACK.
- ADDRESS_ACK: drive SDA low for the 9th SCL period. Set `busy`.
- REGISTER_ADDRESS: shift 8 bits into the pointer. Then REGISTER_ACK, which always ACKs. Then WRITE_DATA.
- WRITE_DATA: shift 8 bits. In WRITE_ACK:
  - Always ACK.
  - If pointer < `REGISTER_DEPTH`: store the byte and pulse `write_strobe`.
  - Increment the pointer.
- READ_DATA: load `reg[pointer]` (8'hFF if out of range) at the ACK falling edge. Shift it out on SDA. Then READ_ACK.
- READ_ACK: release SDA and sample the master's bit.
  - ACK (0): increment the pointer, go to READ_DATA.
  - NACK (1): go to IGNORE.
- IGNORE: SDA released. Wait for STOP or START.

Pointer and boundary rules:
- The pointer is 8-bit and wraps 8'hFF→8'h00.
- Bus writes win over nothing; the local side has no write path.
- Reset mid-transaction: state IDLE, SDA released, registers cleared. The master then sees NACK or data 8'hFF.

## Timing
Reset values:
- SDA released.
- `busy`=0, `write_strobe`=0, `write_address`=0, `write_data`=0.
- All registers 8'h00.
- Pointer 0.

Latencies:
- Bus pin to internal event: 3 clocks (2 synchronizer clocks plus 1 edge register).
- SDA drive change: within 4 clocks of the SCL falling edge at the pin.
- `write_strobe`: asserts 1 clock after the SCL falling edge that ends the 8th data bit. The register file is updated on the same edge.

Bus requirements:
- SCL high and low phases must each be at least 8 `clock` periods.
- SDA setup to SCL at the pin must be at least 4 periods.
- A START or STOP detected on the same clock as an SCL edge takes priority.

## Structure
- Package `i2c_responder_pkg` holds:
  - the state enum (IDLE, DEVICE_ADDRESS, ADDRESS_ACK, REGISTER_ADDRESS, REGISTER_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK, IGNORE)
  - `BYTE_WIDTH`=8
  - `ACK`=1'b0, `NACK`=1'b1
- Sub-module `i2c_bus_conditioner` contains the synchronizers, the SCL rise/fall pulses, and START/STOP detection.
- The top level contains the FSM, the shift register, the pointer and the register file.

## Test plan
- Write 0xA5 to reg 0x03 at address 0x11:
  - three ACKs on the bus
  - `write_strobe` pulses once with `write_address`=0x03 and `write_data`=0xA5
  - `user_read_data`=0xA5 at `user_address`=0x03
- Read reg 0x03 (repeated START, master NACK) → master `miso_data`=0xA5, `busy` falls after STOP.
- Address 0x22 → NACK on the address byte, no strobe, `busy` stays 0, SDA never driven.
- Burst write 0x11, 0x22 from reg 0x0E, then burst read 3 bytes from 0x0E → 0x11, 0x22, 0xFF (0x10 is out of range).
- STOP after 4 data bits → no write, IDLE, SDA released. The next transaction works normally.
- Assert `reset_n` low for 1 clock mid-read → SDA released within 1 clock, registers read 0x00.
